// File: rtl/neuron_accum_stage.sv
`default_nettype none
// ============================================================================
// Module   : neuron_accum_stage
// Brief    : Sums TERMS signed datapath results plus a bias. Saturates the sum
//            to N bits, applies optional ReLU, and emits it via valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module neuron_accum_stage #(
    parameter int N     = 16,
    parameter int TERMS = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] Y,
    input  logic         co,
    input  logic [N-1:0] bias,
    input  logic         relu_en,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_sat,
    output logic         out_co
);

    localparam int ACC_W = N + $clog2(TERMS) + 1;
    localparam int CNT_W = $clog2(TERMS);

    localparam logic [0:0] c_ST_ACCUM = 1'b0;
    localparam logic [0:0] c_ST_OUT   = 1'b1;

    localparam logic [CNT_W-1:0]        c_CNT_LAST = CNT_W'(TERMS - 1);
    localparam logic signed [ACC_W-1:0] c_SAT_MAX  = {{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_SAT_MIN  = {{(ACC_W-N+1){1'b1}}, {(N-1){1'b0}}};

    logic [0:0]              r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic signed [ACC_W-1:0] r_acc;
    logic                    r_co;
    logic                    r_relu;
    logic [N-1:0]            r_out_data;
    logic                    r_out_sat;
    logic                    r_out_co;

    logic                    w_accept;
    logic                    w_first;
    logic                    w_last;
    logic signed [ACC_W-1:0] w_base;
    logic signed [ACC_W-1:0] w_sum;
    logic [N-1:0]            w_clamped;
    logic [N-1:0]            w_result;
    logic                    w_sat;

    assign in_ready  = (r_state == c_ST_ACCUM);
    assign out_valid = (r_state == c_ST_OUT);
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;
    assign out_co    = r_out_co;

    assign w_accept = in_valid && in_ready;
    assign w_first  = (r_cnt == '0);
    assign w_last   = (r_cnt == c_CNT_LAST);

    // The first term starts from the bias instead of the stale accumulator.
    assign w_base = w_first ? {{(ACC_W-N){bias[N-1]}}, bias} : r_acc;
    assign w_sum  = w_base + {{(ACC_W-N){Y[N-1]}}, Y};

    always_comb begin
        w_sat     = 1'b0;
        w_clamped = w_sum[N-1:0];
        if (w_sum > c_SAT_MAX) begin
            w_clamped = c_SAT_MAX[N-1:0];
            w_sat     = 1'b1;
        end else if (w_sum < c_SAT_MIN) begin
            w_clamped = c_SAT_MIN[N-1:0];
            w_sat     = 1'b1;
        end
        w_result = (r_relu && w_clamped[N-1]) ? '0 : w_clamped;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_ACCUM;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_co       <= 1'b0;
            r_relu     <= 1'b0;
            r_out_data <= '0;
            r_out_sat  <= 1'b0;
            r_out_co   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_ACCUM: begin
                    if (w_accept) begin
                        if (w_first) begin
                            r_relu <= relu_en;
                            r_co   <= co;
                        end else begin
                            r_co <= r_co | co;
                        end
                        if (w_last) begin
                            r_out_data <= w_result;
                            r_out_sat  <= w_sat;
                            r_out_co   <= r_co | co;
                            r_cnt      <= '0;
                            r_state    <= c_ST_OUT;
                        end else begin
                            r_acc <= w_sum;
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                c_ST_OUT: begin
                    if (out_ready) begin
                        r_state <= c_ST_ACCUM;
                    end
                end
                default: r_state <= c_ST_ACCUM;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_neuron_accum_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_neuron_accum_stage
// Brief    : Scoreboard bench for neuron_accum_stage with N=16, TERMS=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_neuron_accum_stage;

    localparam int N     = 16;
    localparam int TERMS = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] Y = '0;
    logic         co = 1'b0;
    logic [N-1:0] bias = '0;
    logic         relu_en = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] out_data;
    logic         out_sat;
    logic         out_co;

    neuron_accum_stage #(.N(N), .TERMS(TERMS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Y         (Y),
        .co        (co),
        .bias      (bias),
        .relu_en   (relu_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_co    (out_co)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] d;
        logic         s;
        logic         c;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state: one neuron in progress, plain integer arithmetic.
    int   m_cnt  = 0;
    int   m_sum  = 0;
    bit   m_relu = 1'b0;
    bit   m_co   = 1'b0;

    bit   rdy_random = 1'b0;
    bit   rdy_fixed  = 1'b1;

    always @(posedge clk) begin
        #2;
        out_ready = rdy_random ? ($urandom_range(0, 3) != 0) : rdy_fixed;
    end

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: any presented output must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst) begin
            check("valid_ready_exclusive", int'(out_valid && in_ready), 0);
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    check("out_data", int'($signed(out_data)), int'($signed(sb[0].d)));
                    check("out_sat", int'(out_sat), int'(sb[0].s));
                    check("out_co", int'(out_co), int'(sb[0].c));
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    function automatic exp_t model_finish(input int s, input bit r, input bit c);
        exp_t e;
        int   d;
        e.s = 1'b0;
        d   = s;
        if (s > 32767) begin
            d   = 32767;
            e.s = 1'b1;
        end else if (s < -32768) begin
            d   = -32768;
            e.s = 1'b1;
        end
        if (r && d < 0) d = 0;
        e.d = d[N-1:0];
        e.c = c;
        return e;
    endfunction

    task automatic send_term(input int y, input bit c, input int b, input bit r, input int gap);
        bit acc;
        int tries;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        Y        = y[N-1:0];
        co       = c;
        bias     = b[N-1:0];
        relu_en  = r;
        in_valid = 1'b1;
        acc      = 1'b0;
        tries    = 0;
        while (!acc && tries < 100) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            tries++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            check("accept_timeout", 0, 1);
            return;
        end
        if (m_cnt == 0) begin
            m_sum  = b;
            m_relu = r;
            m_co   = 1'b0;
        end
        m_sum += y;
        m_co  |= c;
        m_cnt++;
        if (m_cnt == TERMS) begin
            sb.push_back(model_finish(m_sum, m_relu, m_co));
            m_cnt = 0;
            @(negedge clk);
            check("latency_out_valid", int'(out_valid), 1);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic neuron4(input int b, input bit r, input int y0, input int y1,
                           input int y2, input int y3, input logic [3:0] com, input int gapmax);
        send_term(y0, com[0], b, r, $urandom_range(0, gapmax));
        send_term(y1, com[1], 1234, !r, $urandom_range(0, gapmax));
        send_term(y2, com[2], -77, !r, $urandom_range(0, gapmax));
        send_term(y3, com[3], 999, !r, $urandom_range(0, gapmax));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        m_cnt = 0;
        @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
    endtask

    initial begin
        int b;
        int y;
        int mode;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_out_data", int'(out_data), 0);
        check("reset_out_sat", int'(out_sat), 0);
        check("reset_out_co", int'(out_co), 0);
        @(posedge clk);
        #1;

        neuron4(10, 1'b0, 1, 2, 3, 4, 4'b0000, 0);
        neuron4(0, 1'b0, 32767, 32767, 32767, 32767, 4'b0000, 0);
        neuron4(0, 1'b0, -32768, -32768, -32768, -32768, 4'b0000, 0);
        neuron4(0, 1'b1, -32768, -32768, -32768, -32768, 4'b0000, 0);
        neuron4(-5, 1'b1, 1, 1, 1, 1, 4'b0000, 0);
        neuron4(-5, 1'b0, 1, 1, 1, 1, 4'b0000, 0);

        // Backpressure: terms offered while the output waits must be ignored.
        rdy_fixed = 1'b0;
        neuron4(7, 1'b0, 10, 20, 30, 40, 4'b0000, 0);
        Y        = 16'd99;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", int'(in_ready), 0);
            check("stall_out_valid", int'(out_valid), 1);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        rdy_fixed = 1'b1;
        neuron4(0, 1'b0, 1, 1, 1, 1, 4'b0000, 0);

        neuron4(0, 1'b0, 5, 6, 7, 8, 4'b0010, 0);
        neuron4(0, 1'b0, 5, 6, 7, 8, 4'b0000, 3);

        send_term(100, 1'b1, 0, 1'b0, 0);
        send_term(100, 1'b1, 0, 1'b0, 0);
        do_reset();
        @(posedge clk);
        #1;
        neuron4(0, 1'b0, 1, 2, 3, 4, 4'b0000, 0);

        rdy_fixed = 1'b0;
        neuron4(3, 1'b0, 1, 1, 1, 1, 4'b1111, 0);
        do_reset();
        rdy_fixed = 1'b1;
        @(posedge clk);
        #1;

        rdy_random = 1'b1;
        for (int n = 0; n < 40; n++) begin
            mode = $urandom_range(0, 2);
            case (mode)
                0:       b = $urandom_range(0, 200) - 100;
                1:       b = $urandom_range(0, 65535) - 32768;
                default: b = $urandom_range(20000, 32767);
            endcase
            for (int t = 0; t < TERMS; t++) begin
                case (mode)
                    0:       y = $urandom_range(0, 200) - 100;
                    1:       y = $urandom_range(0, 65535) - 32768;
                    default: y = ($urandom_range(0, 1) != 0) ? $urandom_range(10000, 32767)
                                                             : -$urandom_range(10000, 32768);
                endcase
                send_term(y, ($urandom_range(0, 4) == 0), (t == 0) ? b : $urandom_range(0, 65535) - 32768,
                          $urandom_range(0, 1), $urandom_range(0, 2));
            end
        end

        rdy_random = 1'b0;
        rdy_fixed  = 1'b1;
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check("drain_scoreboard_empty", sb.size(), 0);
        check("drain_out_valid_low", int'(out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
